mc_control_fsm: RTL

//  Multi-cycle control sequencer for the RV32I datapath: steps each instruction through IF/ID/EX/MEM/WB.

---
 rtl/mc_ctrl_pkg.sv | 36 +++
 rtl/mc_opcode_decode.sv | 23 ++
 rtl/mc_control_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared state, instruction-class and control-code definitions for the multi-cycle control sequencer.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_IALU, CLS_LD, CLS_ST, CLS_BR, CLS_JAL, CLS_JALR, CLS_ECALL, CLS_ILL
  } instr_cls_t;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MDR   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  localparam logic [1:0] SRCB_RS2 = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_BR    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational RV32I opcode to instruction-class decode; anything unrecognised maps to CLS_ILL.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output instr_cls_t cls
);

  always_comb begin
    case (opcode)
      OP_ALU:   cls = CLS_ALU;
      OP_IALU:  cls = CLS_IALU;
      OP_LD:    cls = CLS_LD;
      OP_ST:    cls = CLS_ST;
      OP_BR:    cls = CLS_BR;
      OP_JAL:   cls = CLS_JAL;
      OP_JALR:  cls = CLS_JALR;
      OP_ECALL: cls = CLS_ECALL;
      default:  cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer; strobes decode from the state register plus opcode/bcond/mem_ready.
// Performance counters exist only when MC_PERF_CNT_EN is defined, otherwise both count ports read zero.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic             is_halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  state_t     state;
  instr_cls_t cls;

  mc_opcode_decode u_dec (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IF;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IF: if (mem_ready) state <= ST_ID;
        ST_ID: begin
          case (cls)
            CLS_ECALL: state <= halt_req ? ST_HALT : ST_IF;
            CLS_ILL: begin
              illegal <= 1'b1;
              state   <= ST_IF;
            end
            default:   state <= ST_EX;
          endcase
        end
        ST_EX: begin
          case (cls)
            CLS_ALU, CLS_IALU, CLS_JAL, CLS_JALR: state <= ST_WB;
            CLS_LD, CLS_ST:                       state <= ST_MEM;
            default:                              state <= ST_IF;
          endcase
        end
        ST_MEM: if (mem_ready) state <= (cls == CLS_LD) ? ST_WB : ST_IF;
        ST_WB:   state <= ST_IF;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IF;
      endcase
    end
  end

  // Strobes are forced low while reset is asserted, even if the state register still holds MEM.
  always_comb begin
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    if (!reset) begin
      case (state)
        ST_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        ST_ID: begin
          if ((cls == CLS_ECALL && !halt_req) || cls == CLS_ILL) begin
            pc_write = 1'b1;
            pc_src   = PC_PLUS4;
          end
        end
        ST_EX: begin
          case (cls)
            CLS_ALU: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_RS2;
              alu_op    = ALUOP_FUNCT;
            end
            CLS_IALU: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALUOP_FUNCT;
            end
            CLS_LD, CLS_ST, CLS_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALUOP_ADD;
            end
            CLS_JAL: begin
              alu_src_a = 1'b0;
              alu_src_b = SRCB_IMM;
              alu_op    = ALUOP_ADD;
            end
            CLS_BR: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_RS2;
              alu_op    = ALUOP_BR;
              pc_write  = 1'b1;
              pc_src    = bcond ? PC_REL : PC_PLUS4;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          iord      = 1'b1;
          mem_read  = (cls == CLS_LD);
          mem_write = (cls == CLS_ST);
          if (cls == CLS_ST && mem_ready) begin
            pc_write = 1'b1;
            pc_src   = PC_PLUS4;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          case (cls)
            CLS_LD:   wb_sel = WB_MDR;
            CLS_JAL: begin
              wb_sel = WB_PC4;
              pc_src = PC_REL;
            end
            CLS_JALR: begin
              wb_sel = WB_PC4;
              pc_src = PC_ALU;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign is_halted = (state == ST_HALT);

`ifdef MC_PERF_CNT_EN
  logic retire;
  assign retire = pc_write || (!reset && state == ST_ID && cls == CLS_ECALL && halt_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state != ST_HALT) cycle_count <= cycle_count + 1'b1;
      if (retire)           instret_count <= instret_count + 1'b1;
    end
  end
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule
